riscv_multicycle_controller: RTL and testbench
==============================================

Name: riscv_multicycle_controller

Overview:
- Moore/Mealy FSM that sequences the multi-cycle RV32I datapath: shared instruction/data memory, PC, OldPC, IR, MDR, A, B and ALUOut registers.
- Decodes opc/f3/f7 and drives every register enable and datapath mux, one state per cycle.
- Supports lw, sw, R-type (add, sub, and, or, slt, sltu), I-type ALU (addi, xori, ori, slti, sltiu), beq, bne, blt, bge, jal, jalr and lui.
- Memory accesses stall on a ready handshake.

Parameters:
- USE_MEM_READY, 1: when 0, mem_ready is ignored and treated as constant 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- zero  in  1  ALU result == 0.
- sign  in  1  ALU result MSB (signed less-than for sub).
- opc  in  7  IR[6:0].
- f3  in  3  IR[14:12].
- f7  in  7  IR[31:25].
- mem_ready  in  1  memory completes the current access this cycle.
- PCwrite  out  1  PC <= result.
- adrsrc  out  1  memory address select: 0 = PC, 1 = result.
- IRwrite  out  1  IR <= mem, OldPC <= PC.
- memwrite  out  1  memory write strobe.
- regwrite  out  1  register file write.
- ALUsrcA  out  2  00 = PC, 01 = OldPC, 10 = A.
- ALUsrcB  out  2  00 = B, 01 = imm, 10 = const 4.
- ALUcontrol  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sltu.
- Imsrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- resultsrc  out  2  00 = ALUOut, 01 = MDR, 10 = ALU result, 11 = imm.
- illegal  out  1  one-cycle pulse when an unsupported encoding is decoded.

Behaviour:
- Reset (async, rst=1):
  - State goes to FETCH.
  - PCwrite, IRwrite, memwrite, regwrite and illegal are forced to 0 while rst=1.
  - All mux selects default to 0.
- Output rule: any output not listed for a state is 0.
- FETCH:
  - Drives adrsrc=0, ALUsrcA=00, ALUsrcB=10, ALUcontrol=add, resultsrc=10.
  - IRwrite and PCwrite are asserted only in the cycle mem_ready=1; move to DECODE in that cycle, otherwise hold.
  - No PC double increment is allowed on stalls.
- DECODE:
  - Drives ALUsrcA=01, ALUsrcB=01, add, so ALUOut = OldPC+imm (branch/jal target).
  - Imsrc is set per opc.
  - Next state by opc:
    - 3 and 35 -> MEMADR.
    - 51 -> EXECR.
    - 19 -> EXECI.
    - 99 -> BRANCH.
    - 111 -> JAL.
    - 103 -> JALR.
    - 55 -> LUI.
    - Any other opc -> FETCH with illegal=1.
- MEMADR: A=10, B=01, add, Imsrc = I for lw / S for sw. lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: adrsrc=1, resultsrc=00. Hold until mem_ready, then -> MEMWB.
- MEMWB: resultsrc=01, regwrite=1 -> FETCH.
- MEMWRITE:
  - adrsrc=1, resultsrc=00, memwrite=1 held until mem_ready.
  - -> FETCH in the mem_ready cycle.
- EXECR: A=10, B=00, ALUcontrol from f3/f7 -> ALUWB.
- EXECI: A=10, B=01, Imsrc=I, ALUcontrol from f3 -> ALUWB.
- ALUWB: resultsrc=00, regwrite=1 -> FETCH.
- BRANCH:
  - A=10, B=00, sub, resultsrc=00.
  - PCwrite is taken as follows: beq = zero; bne = ~zero; blt = sign; bge = ~sign.
  - -> FETCH.
- JAL: resultsrc=00, PCwrite=1 -> LINK.
- JALR: A=10, B=01, Imsrc=I, add, resultsrc=10, PCwrite=1 -> LINK.
- LINK: A=01, B=10, add, resultsrc=10, regwrite=1 (rd <= OldPC+4) -> FETCH.
- LUI: Imsrc=U, resultsrc=11, regwrite=1 -> FETCH.
- Illegal encodings:
  - Cases: unsupported f3/f7 in EXECR/EXECI/BRANCH, and jalr or lw/sw with wrong f3.
  - These are detected in DECODE: illegal=1, -> FETCH, no write enables.
- Reset mid-access: any state, including a stalled MEMWRITE, aborts immediately; memwrite drops combinationally with rst.
- Latency in cycles, mem_ready=1:
  - lw 5.
  - sw 4.
  - R/I 4.
  - branch 3.
  - jal/jalr 4.
  - lui 3.
- Each memory stall cycle adds 1.

Decomposition:
- Shared package riscv_pkg holds:
  - Opcode constants: 3, 35, 51, 19, 99, 111, 103, 55.
  - ALUcontrol, Imsrc, resultsrc and ALUsrcA/B encodings.
  - State enum.
- Sub-module alu_decoder: combinational mapping from (opc, f3, f7) to ALUcontrol plus a legal flag. It is shared with the single-cycle design.

Test Plan:
- Reset: assert rst mid-MEMWRITE with mem_ready=0 -> memwrite=0 immediately; after release state is FETCH and PCwrite pulses only when mem_ready=1.
- lw (opc=3, f3=2), mem_ready=1 -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB; regwrite=1 with resultsrc=01 in cycle 5 only.
- Fetch stall: mem_ready low for 3 cycles -> IRwrite/PCwrite stay 0, then exactly one pulse.
- Branch table, f3=0/1/4/5 crossed with {zero, sign} = 00/01/10 -> PCwrite per the rule above; e.g. bge with sign=1 gives 0, blt with sign=1 gives 1.
- R-type f3=0 with f7=32 -> ALUcontrol=001 in EXECR. I-type f3=4 -> ALUcontrol=100. opc=51, f3=0, f7=1 -> illegal=1, back to FETCH, no regwrite.
- jal then jalr -> PCwrite in JAL/JALR, then LINK with regwrite=1, ALUsrcA=01, ALUsrcB=10; lui -> regwrite with resultsrc=11, Imsrc=100.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I multi-cycle controller and its ALU decoder.
package riscv_pkg;

  // Major opcodes (IR[6:0])
  localparam logic [6:0] OpLoad   = 7'd3;
  localparam logic [6:0] OpStore  = 7'd35;
  localparam logic [6:0] OpRType  = 7'd51;
  localparam logic [6:0] OpIType  = 7'd19;
  localparam logic [6:0] OpBranch = 7'd99;
  localparam logic [6:0] OpJal    = 7'd111;
  localparam logic [6:0] OpJalr   = 7'd103;
  localparam logic [6:0] OpLui    = 7'd55;

  // ALUcontrol
  localparam logic [2:0] AluAdd  = 3'b000;
  localparam logic [2:0] AluSub  = 3'b001;
  localparam logic [2:0] AluAnd  = 3'b010;
  localparam logic [2:0] AluOr   = 3'b011;
  localparam logic [2:0] AluXor  = 3'b100;
  localparam logic [2:0] AluSlt  = 3'b101;
  localparam logic [2:0] AluSltu = 3'b110;

  // Imsrc
  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmJ = 3'b011;
  localparam logic [2:0] ImmU = 3'b100;

  // resultsrc
  localparam logic [1:0] ResAluOut = 2'b00;
  localparam logic [1:0] ResMdr    = 2'b01;
  localparam logic [1:0] ResAlu    = 2'b10;
  localparam logic [1:0] ResImm    = 2'b11;

  // ALUsrcA / ALUsrcB
  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcAReg   = 2'b10;
  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBImm   = 2'b01;
  localparam logic [1:0] SrcBFour  = 2'b10;

  // Controller states
  typedef logic [3:0] state_t;
  localparam state_t StFetch    = 4'd0;
  localparam state_t StDecode   = 4'd1;
  localparam state_t StMemAdr   = 4'd2;
  localparam state_t StMemRead  = 4'd3;
  localparam state_t StMemWb    = 4'd4;
  localparam state_t StMemWrite = 4'd5;
  localparam state_t StExecR    = 4'd6;
  localparam state_t StExecI    = 4'd7;
  localparam state_t StAluWb    = 4'd8;
  localparam state_t StBranch   = 4'd9;
  localparam state_t StJal      = 4'd10;
  localparam state_t StJalr     = 4'd11;
  localparam state_t StLink     = 4'd12;
  localparam state_t StLui      = 4'd13;

  // Immediate format implied by the opcode
  function automatic logic [2:0] imm_src_for(input logic [6:0] opc);
    case (opc)
      OpStore:  return ImmS;
      OpBranch: return ImmB;
      OpJal:    return ImmJ;
      OpLui:    return ImmU;
      default:  return ImmI;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps (opc, f3, f7) to an ALU operation and flags encodings the core does not support.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] opc_i,
  input  logic [2:0] f3_i,
  input  logic [6:0] f7_i,
  output logic [2:0] alu_ctrl_o,
  output logic       legal_o
);

  // Operation select and legality per opcode class
  always_comb begin
    alu_ctrl_o = AluAdd;
    legal_o    = 1'b0;
    case (opc_i)
      OpRType: begin
        case (f3_i)
          3'd0: begin
            if (f7_i == 7'd0) begin
              legal_o = 1'b1;
            end else if (f7_i == 7'd32) begin
              alu_ctrl_o = AluSub;
              legal_o    = 1'b1;
            end
          end
          3'd2: begin alu_ctrl_o = AluSlt;  legal_o = (f7_i == 7'd0); end
          3'd3: begin alu_ctrl_o = AluSltu; legal_o = (f7_i == 7'd0); end
          3'd6: begin alu_ctrl_o = AluOr;   legal_o = (f7_i == 7'd0); end
          3'd7: begin alu_ctrl_o = AluAnd;  legal_o = (f7_i == 7'd0); end
          default: ;
        endcase
      end
      OpIType: begin
        case (f3_i)
          3'd0: begin alu_ctrl_o = AluAdd;  legal_o = 1'b1; end
          3'd2: begin alu_ctrl_o = AluSlt;  legal_o = 1'b1; end
          3'd3: begin alu_ctrl_o = AluSltu; legal_o = 1'b1; end
          3'd4: begin alu_ctrl_o = AluXor;  legal_o = 1'b1; end
          3'd6: begin alu_ctrl_o = AluOr;   legal_o = 1'b1; end
          default: ;
        endcase
      end
      OpBranch: begin
        alu_ctrl_o = AluSub;
        legal_o    = (f3_i == 3'd0) || (f3_i == 3'd1) || (f3_i == 3'd4) || (f3_i == 3'd5);
      end
      OpLoad, OpStore: legal_o = (f3_i == 3'd2);
      OpJalr:          legal_o = (f3_i == 3'd0);
      OpJal, OpLui:    legal_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_controller.sv
// Control FSM for the multi-cycle RV32I datapath: one state per cycle, memory stalls on mem_ready.
module riscv_multicycle_controller
  import riscv_pkg::*;
#(
  parameter int unsigned USE_MEM_READY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       zero,
  input  logic       sign,
  input  logic [6:0] opc,
  input  logic [2:0] f3,
  input  logic [6:0] f7,
  input  logic       mem_ready,
  output logic       PCwrite,
  output logic       adrsrc,
  output logic       IRwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic [1:0] ALUsrcA,
  output logic [1:0] ALUsrcB,
  output logic [2:0] ALUcontrol,
  output logic [2:0] Imsrc,
  output logic [1:0] resultsrc,
  output logic       illegal
);

  state_t     state_q, state_d;
  logic [2:0] dec_alu_ctrl;
  logic       dec_legal;
  logic       rdy;

  alu_decoder u_alu_decoder (
    .opc_i      (opc),
    .f3_i       (f3),
    .f7_i       (f7),
    .alu_ctrl_o (dec_alu_ctrl),
    .legal_o    (dec_legal)
  );

  assign rdy = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

  // Next-state and per-state outputs; everything is masked while rst is high
  always_comb begin
    state_d    = state_q;
    PCwrite    = 1'b0;
    adrsrc     = 1'b0;
    IRwrite    = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    ALUsrcA    = SrcAPc;
    ALUsrcB    = SrcBReg;
    ALUcontrol = AluAdd;
    Imsrc      = ImmI;
    resultsrc  = ResAluOut;
    illegal    = 1'b0;

    case (state_q)
      StFetch: begin
        ALUsrcB   = SrcBFour;
        resultsrc = ResAlu;
        // PC and IR only update on the completing cycle so a stall never double-increments
        if (rdy) begin
          IRwrite = 1'b1;
          PCwrite = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        ALUsrcA = SrcAOldPc;
        ALUsrcB = SrcBImm;
        Imsrc   = imm_src_for(opc);
        if (!dec_legal) begin
          illegal = 1'b1;
          state_d = StFetch;
        end else begin
          case (opc)
            OpLoad, OpStore: state_d = StMemAdr;
            OpRType:         state_d = StExecR;
            OpIType:         state_d = StExecI;
            OpBranch:        state_d = StBranch;
            OpJal:           state_d = StJal;
            OpJalr:          state_d = StJalr;
            OpLui:           state_d = StLui;
            default:         state_d = StFetch;
          endcase
        end
      end
      StMemAdr: begin
        ALUsrcA = SrcAReg;
        ALUsrcB = SrcBImm;
        Imsrc   = imm_src_for(opc);
        state_d = (opc == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        adrsrc = 1'b1;
        if (rdy) state_d = StMemWb;
      end
      StMemWb: begin
        resultsrc = ResMdr;
        regwrite  = 1'b1;
        state_d   = StFetch;
      end
      StMemWrite: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
        if (rdy) state_d = StFetch;
      end
      StExecR: begin
        ALUsrcA    = SrcAReg;
        ALUcontrol = dec_alu_ctrl;
        state_d    = StAluWb;
      end
      StExecI: begin
        ALUsrcA    = SrcAReg;
        ALUsrcB    = SrcBImm;
        ALUcontrol = dec_alu_ctrl;
        state_d    = StAluWb;
      end
      StAluWb: begin
        regwrite = 1'b1;
        state_d  = StFetch;
      end
      StBranch: begin
        ALUsrcA    = SrcAReg;
        ALUcontrol = AluSub;
        case (f3)
          3'd0:    PCwrite = zero;
          3'd1:    PCwrite = ~zero;
          3'd4:    PCwrite = sign;
          3'd5:    PCwrite = ~sign;
          default: PCwrite = 1'b0;
        endcase
        state_d = StFetch;
      end
      StJal: begin
        PCwrite = 1'b1;
        state_d = StLink;
      end
      StJalr: begin
        ALUsrcA   = SrcAReg;
        ALUsrcB   = SrcBImm;
        resultsrc = ResAlu;
        PCwrite   = 1'b1;
        state_d   = StLink;
      end
      StLink: begin
        // rd <= OldPC + 4
        ALUsrcA   = SrcAOldPc;
        ALUsrcB   = SrcBFour;
        resultsrc = ResAlu;
        regwrite  = 1'b1;
        state_d   = StFetch;
      end
      StLui: begin
        Imsrc     = ImmU;
        resultsrc = ResImm;
        regwrite  = 1'b1;
        state_d   = StFetch;
      end
      default: state_d = StFetch;
    endcase

    if (rst) begin
      PCwrite    = 1'b0;
      adrsrc     = 1'b0;
      IRwrite    = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      ALUsrcA    = SrcAPc;
      ALUsrcB    = SrcBReg;
      ALUcontrol = AluAdd;
      Imsrc      = ImmI;
      resultsrc  = ResAluOut;
      illegal    = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StFetch;
    else     state_q <= state_d;
  end

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Directed bench for riscv_multicycle_controller with hand-computed expectations.
module tb_riscv_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       zero, sign, mem_ready;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic       PCwrite, adrsrc, IRwrite, memwrite, regwrite, illegal;
  logic [1:0] ALUsrcA, ALUsrcB, resultsrc;
  logic [2:0] ALUcontrol, Imsrc;

  int total = 0;
  int bad   = 0;

  logic [2:0] br_f3  [4];
  logic [2:0] br_exp [4];

  always #5 clk = ~clk;

  riscv_multicycle_controller #(.USE_MEM_READY(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .zero       (zero),
    .sign       (sign),
    .opc        (opc),
    .f3         (f3),
    .f7         (f7),
    .mem_ready  (mem_ready),
    .PCwrite    (PCwrite),
    .adrsrc     (adrsrc),
    .IRwrite    (IRwrite),
    .memwrite   (memwrite),
    .regwrite   (regwrite),
    .ALUsrcA    (ALUsrcA),
    .ALUsrcB    (ALUsrcB),
    .ALUcontrol (ALUcontrol),
    .Imsrc      (Imsrc),
    .resultsrc  (resultsrc),
    .illegal    (illegal)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Land 3 time units after the next rising edge
  task automatic next();
    @(posedge clk);
    #3;
  endtask

  // In FETCH: complete the fetch and present the new instruction fields, ending in DECODE
  task automatic do_fetch(input logic [6:0] o, input logic [2:0] f, input logic [6:0] s);
    mem_ready = 1'b1;
    opc = o; f3 = f; f7 = s;
    #1;
    chk("fetch_irwrite", 8'(IRwrite), 8'd1);
    next();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    br_f3[0] = 3'd0; br_exp[0] = 3'b100;  // beq: {z,s}=00->0, 01->0, 10->1
    br_f3[1] = 3'd1; br_exp[1] = 3'b011;  // bne: 1,1,0
    br_f3[2] = 3'd4; br_exp[2] = 3'b010;  // blt: 0,1,0
    br_f3[3] = 3'd5; br_exp[3] = 3'b101;  // bge: 1,0,1

    rst = 1'b1; zero = 1'b0; sign = 1'b0; opc = 7'd0; f3 = 3'd0; f7 = 7'd0;
    mem_ready = 1'b1;
    #3;
    chk("rst_pcwrite",   8'(PCwrite),   8'd0);
    chk("rst_irwrite",   8'(IRwrite),   8'd0);
    chk("rst_alusrcb",   8'(ALUsrcB),   8'd0);
    chk("rst_resultsrc", 8'(resultsrc), 8'd0);

    // Fetch stall: three cycles with mem_ready low, then a single pulse
    next();
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_irwrite", 8'(IRwrite), 8'd0);
      chk("stall_pcwrite", 8'(PCwrite), 8'd0);
      chk("stall_alusrcb", 8'(ALUsrcB), 8'd2);
      next();
    end
    mem_ready = 1'b1; opc = 7'd3; f3 = 3'd2;
    #1;
    chk("fetch_pcwrite",   8'(PCwrite),   8'd1);
    chk("fetch_irwrite1",  8'(IRwrite),   8'd1);
    chk("fetch_resultsrc", 8'(resultsrc), 8'd2);

    // lw: DECODE, MEMADR, MEMREAD, MEMWB
    next();
    chk("lw_dec_pcwrite", 8'(PCwrite), 8'd0);
    chk("lw_dec_irwrite", 8'(IRwrite), 8'd0);
    chk("lw_dec_srca",    8'(ALUsrcA), 8'd1);
    chk("lw_dec_srcb",    8'(ALUsrcB), 8'd1);
    chk("lw_dec_illegal", 8'(illegal), 8'd0);
    next();
    chk("lw_adr_srca",     8'(ALUsrcA),  8'd2);
    chk("lw_adr_regwrite", 8'(regwrite), 8'd0);
    next();
    chk("lw_rd_adrsrc",   8'(adrsrc),   8'd1);
    chk("lw_rd_regwrite", 8'(regwrite), 8'd0);
    next();
    chk("lw_wb_regwrite",  8'(regwrite),  8'd1);
    chk("lw_wb_resultsrc", 8'(resultsrc), 8'd1);
    next();
    chk("lw_done_regwrite", 8'(regwrite), 8'd0);

    // Branch table
    for (int b = 0; b < 4; b++) begin
      for (int c = 0; c < 3; c++) begin
        do_fetch(7'd99, br_f3[b], 7'd0);
        chk("br_dec_imsrc", 8'(Imsrc), 8'd2);
        next();
        zero = (c == 2);
        sign = (c == 1);
        #1;
        chk($sformatf("br_pcwrite_f3_%0d_c%0d", br_f3[b], c), 8'(PCwrite), 8'(br_exp[b][c]));
        chk("br_aluctl", 8'(ALUcontrol), 8'd1);
        zero = 1'b0; sign = 1'b0;
        next();
      end
    end

    // R-type sub
    do_fetch(7'd51, 3'd0, 7'd32);
    next();
    chk("sub_aluctl", 8'(ALUcontrol), 8'd1);
    chk("sub_srca",   8'(ALUsrcA),    8'd2);
    chk("sub_srcb",   8'(ALUsrcB),    8'd0);
    next();
    chk("sub_wb_regwrite", 8'(regwrite), 8'd1);
    next();

    // I-type xori
    do_fetch(7'd19, 3'd4, 7'd0);
    next();
    chk("xori_aluctl", 8'(ALUcontrol), 8'd4);
    chk("xori_srcb",   8'(ALUsrcB),    8'd1);
    next();
    chk("xori_wb_regwrite", 8'(regwrite), 8'd1);
    next();

    // Illegal R-type and unknown opcode
    do_fetch(7'd51, 3'd0, 7'd1);
    chk("ill_r_illegal",  8'(illegal),  8'd1);
    chk("ill_r_regwrite", 8'(regwrite), 8'd0);
    next();
    chk("ill_r_back_fetch", 8'(ALUsrcB), 8'd2);
    chk("ill_r_pulse_end",  8'(illegal), 8'd0);
    do_fetch(7'd15, 3'd0, 7'd0);
    chk("ill_opc_illegal", 8'(illegal), 8'd1);
    next();

    // jal then jalr
    do_fetch(7'd111, 3'd0, 7'd0);
    chk("jal_dec_imsrc", 8'(Imsrc), 8'd3);
    next();
    chk("jal_pcwrite",   8'(PCwrite),   8'd1);
    chk("jal_resultsrc", 8'(resultsrc), 8'd0);
    next();
    chk("jal_link_regwrite", 8'(regwrite),  8'd1);
    chk("jal_link_srca",     8'(ALUsrcA),   8'd1);
    chk("jal_link_srcb",     8'(ALUsrcB),   8'd2);
    chk("jal_link_res",      8'(resultsrc), 8'd2);
    next();
    do_fetch(7'd103, 3'd0, 7'd0);
    next();
    chk("jalr_pcwrite", 8'(PCwrite),   8'd1);
    chk("jalr_srca",    8'(ALUsrcA),   8'd2);
    chk("jalr_res",     8'(resultsrc), 8'd2);
    next();
    chk("jalr_link_regwrite", 8'(regwrite), 8'd1);
    next();

    // lui
    do_fetch(7'd55, 3'd0, 7'd0);
    chk("lui_dec_imsrc", 8'(Imsrc), 8'd4);
    next();
    chk("lui_regwrite",  8'(regwrite),  8'd1);
    chk("lui_resultsrc", 8'(resultsrc), 8'd3);
    chk("lui_imsrc",     8'(Imsrc),     8'd4);
    next();

    // sw completing immediately
    do_fetch(7'd35, 3'd2, 7'd0);
    chk("sw_dec_imsrc", 8'(Imsrc), 8'd1);
    next();
    next();
    chk("sw_memwrite", 8'(memwrite), 8'd1);
    next();
    chk("sw_done_memwrite", 8'(memwrite), 8'd0);
    chk("sw_done_irwrite",  8'(IRwrite),  8'd1);

    // sw stalled, then reset mid-access
    do_fetch(7'd35, 3'd2, 7'd0);
    next();
    chk("sw2_adr_imsrc", 8'(Imsrc), 8'd1);
    mem_ready = 1'b0;
    next();
    chk("sw2_memwrite", 8'(memwrite), 8'd1);
    chk("sw2_adrsrc",   8'(adrsrc),   8'd1);
    next();
    chk("sw2_stall_memwrite", 8'(memwrite), 8'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_memwrite", 8'(memwrite), 8'd0);
    chk("rst_mid_adrsrc",   8'(adrsrc),   8'd0);
    next();
    rst = 1'b0;
    #1;
    chk("post_rst_irwrite", 8'(IRwrite), 8'd0);
    chk("post_rst_pcwrite", 8'(PCwrite), 8'd0);
    chk("post_rst_fetch",   8'(ALUsrcB), 8'd2);
    next();
    chk("post_rst_hold", 8'(PCwrite), 8'd0);
    mem_ready = 1'b1;
    #1;
    chk("post_rst_pcwrite1", 8'(PCwrite), 8'd1);
    chk("post_rst_irwrite1", 8'(IRwrite), 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
